shift_add_mult_ctrl: RTL and testbench

Sequencer for the team's unsigned shift-and-add multiplier. It captures two WORD_LENGTH operands on a start handshake and drives an external parallel-in/serial-out shift register: one load, then WORD_LENGTH shifts. It consumes the returned LSB-first serial bit stream, accumulates the 2*WORD_LENGTH-bit product, and signals completion with a one-cycle Done pulse.

---
 rtl/mult_pkg.sv | 22 ++
 rtl/mult_bit_counter.sv | 45 ++++
 rtl/shift_add_mult_ctrl.sv | 161 ++++++++++++++++
 tb/tb_shift_add_mult_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the shift-and-add multiplier sequencer
// Purpose: sequencer state encoding, default operand width and bit-counter width.
// Ports: none (package).
package mult_pkg;

    localparam int WORD_LENGTH_DEFAULT = 8;

    // Counter must index bit positions 0..word_length-1.
    function automatic int count_width(input int word_length);
        return (word_length <= 2) ? 1 : $clog2(word_length);
    endfunction

    localparam int COUNT_WIDTH = count_width(WORD_LENGTH_DEFAULT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mult_bit_counter.sv
// rtl/mult_bit_counter.sv - bit-position counter with terminal-count flag
// Purpose: counts serial bit positions 0..WORD_LENGTH-1 for the multiplier sequencer.
// Ports:
//   clk_i    in  rising-edge clock
//   reset_i  in  synchronous active-high reset (clears count)
//   clr_i    in  synchronous clear
//   inc_i    in  increment by one
//   count_o  out current bit position
//   tc_o     out high when count_o == WORD_LENGTH-1
module mult_bit_counter #(
    parameter int WORD_LENGTH = mult_pkg::WORD_LENGTH_DEFAULT,
    parameter int COUNT_WIDTH = mult_pkg::count_width(WORD_LENGTH)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   clr_i,
    input  logic                   inc_i,
    output logic [COUNT_WIDTH-1:0] count_o,
    output logic                   tc_o
);

    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == COUNT_WIDTH'(WORD_LENGTH - 1));

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// rtl/shift_add_mult_ctrl.sv - shift-and-add multiplier sequencer driving an external PISO
// Purpose: captures two unsigned operands on Start, loads the multiplier into an external
// parallel-in/serial-out register, shifts it WORD_LENGTH times and accumulates the product
// from the returned LSB-first bit stream. Optional macro SHIFT_ADD_MULT_ZERO_SKIP_EN makes
// runs with a zero operand skip the load/shift sequence.
// Ports:
//   Clk              in  rising-edge clock
//   Reset            in  synchronous active-high reset
//   Start            in  request, accepted only while Ready=1
//   Multiplicand     in  operand A, captured on accept
//   Multiplier       in  operand B, captured on accept and sent to the PISO
//   Serial_In        in  current LSB of the PISO
//   Ready            out high only in IDLE
//   Done             out one-cycle completion pulse
//   Product          out 2*WORD_LENGTH-bit result, held until the next run completes
//   Piso_Enable      out PISO enable
//   Piso_Shift_Load  out 1 = load Piso_Data, 0 = shift right
//   Piso_Data        out captured Multiplier
module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter int WORD_LENGTH = WORD_LENGTH_DEFAULT
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic [WORD_LENGTH-1:0]   Multiplicand,
    input  logic [WORD_LENGTH-1:0]   Multiplier,
    input  logic                     Serial_In,
    output logic                     Ready,
    output logic                     Done,
    output logic [2*WORD_LENGTH-1:0] Product,
    output logic                     Piso_Enable,
    output logic                     Piso_Shift_Load,
    output logic [WORD_LENGTH-1:0]   Piso_Data
);

    localparam int CNT_W = count_width(WORD_LENGTH);
    localparam int PW    = 2 * WORD_LENGTH;

    state_t                 state_q, state_d;
    logic [WORD_LENGTH-1:0] mcand_q, mcand_d;
    logic [WORD_LENGTH-1:0] piso_data_q, piso_data_d;
    logic [PW-1:0]          acc_q, acc_d;
    logic [PW-1:0]          product_q, product_d;
    logic                   skip_q, skip_d;
    logic                   ready_q, done_q, en_q, sl_q;

    logic                   cnt_clr, cnt_inc, cnt_tc;
    logic [CNT_W-1:0]       cnt;

    logic [PW-1:0]          mcand_ext;
    logic                   zero_operand;

    mult_bit_counter #(
        .WORD_LENGTH (WORD_LENGTH),
        .COUNT_WIDTH (CNT_W)
    ) u_bit_counter (
        .clk_i   (Clk),
        .reset_i (Reset),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .count_o (cnt),
        .tc_o    (cnt_tc)
    );

    assign mcand_ext = {{WORD_LENGTH{1'b0}}, mcand_q};

`ifdef SHIFT_ADD_MULT_ZERO_SKIP_EN
    assign zero_operand = (Multiplicand == '0) || (Multiplier == '0);
`else
    assign zero_operand = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        piso_data_d = piso_data_q;
        acc_d       = acc_q;
        product_d   = product_q;
        skip_d      = skip_q;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    mcand_d     = Multiplicand;
                    piso_data_d = Multiplier;
                    acc_d       = '0;
                    skip_d      = zero_operand;
                    cnt_clr     = 1'b1;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // A skipped run spends this cycle with the PISO disabled so that
                // Done still lands one edge after accept, carrying a zero product.
                if (skip_q) begin
                    product_d = acc_q;
                    state_d   = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Serial_In carries multiplier bit cnt on this edge.
                if (Serial_In) begin
                    acc_d = acc_q + (mcand_ext << cnt);
                end
                cnt_inc = 1'b1;
                if (cnt_tc) begin
                    product_d = acc_d;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from next state and registered so they change
    // together with the state and have no input-to-output paths.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            mcand_q     <= '0;
            piso_data_q <= '0;
            acc_q       <= '0;
            product_q   <= '0;
            skip_q      <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            en_q        <= 1'b0;
            sl_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            piso_data_q <= piso_data_d;
            acc_q       <= acc_d;
            product_q   <= product_d;
            skip_q      <= skip_d;
            ready_q     <= (state_d == ST_IDLE);
            done_q      <= (state_d == ST_DONE);
            en_q        <= ((state_d == ST_LOAD) && !skip_d) || (state_d == ST_RUN);
            sl_q        <= (state_d == ST_LOAD) && !skip_d;
        end
    end

    assign Ready           = ready_q;
    assign Done            = done_q;
    assign Product         = product_q;
    assign Piso_Enable     = en_q;
    assign Piso_Shift_Load = sl_q;
    assign Piso_Data       = piso_data_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// tb/tb_shift_add_mult_ctrl.sv - self-checking bench for shift_add_mult_ctrl
module tb_shift_add_mult_ctrl;

    localparam int N = 8;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Start;
    logic [N-1:0]     Multiplicand;
    logic [N-1:0]     Multiplier;
    logic             Serial_In;
    logic             Ready;
    logic             Done;
    logic [2*N-1:0]   Product;
    logic             Piso_Enable;
    logic             Piso_Shift_Load;
    logic [N-1:0]     Piso_Data;

    logic [N-1:0]     piso_q = '0;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    shift_add_mult_ctrl #(.WORD_LENGTH(N)) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Start           (Start),
        .Multiplicand    (Multiplicand),
        .Multiplier      (Multiplier),
        .Serial_In       (Serial_In),
        .Ready           (Ready),
        .Done            (Done),
        .Product         (Product),
        .Piso_Enable     (Piso_Enable),
        .Piso_Shift_Load (Piso_Shift_Load),
        .Piso_Data       (Piso_Data)
    );

    // External parallel-in/serial-out shift register
    always @(posedge Clk) begin
        if (Piso_Enable === 1'b1) begin
            piso_q <= (Piso_Shift_Load === 1'b1) ? Piso_Data : (piso_q >> 1);
        end
    end
    assign Serial_In = piso_q[0];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_product(input logic [N-1:0] a, input logic [N-1:0] b);
        return 64'(a) * 64'(b);
    endfunction

    function automatic bit ref_skip(input logic [N-1:0] a, input logic [N-1:0] b);
`ifdef SHIFT_ADD_MULT_ZERO_SKIP_EN
        return (a == 0) || (b == 0);
`else
        return 1'b0;
`endif
    endfunction

    // One full transaction; edges are counted from the accept edge E0.
    task automatic run_mult(input logic [N-1:0] a, input logic [N-1:0] b, input bit repulse);
        int k;
        int en_cnt;
        bit skip;
        skip = ref_skip(a, b);
        Multiplicand = a;
        Multiplier   = b;
        Start        = 1'b1;
        @(negedge Clk);
        k = 0;
        Start        = 1'b0;
        Multiplicand = N'($urandom);
        Multiplier   = N'($urandom);
        check("ready_low_after_accept", Ready, 0);
        if (!skip) begin
            check("load_shift_load", Piso_Shift_Load, 1);
            check("load_piso_data", Piso_Data, b);
        end
        en_cnt = 0;
        while (Done !== 1'b1 && k < 40) begin
            if (Piso_Enable === 1'b1) en_cnt++;
            if (repulse) begin
                Start        = (k >= 3 && k <= 6);
                Multiplicand = N'($urandom_range(1, 255));
                Multiplier   = N'($urandom_range(1, 255));
            end
            @(negedge Clk);
            k++;
        end
        Start = 1'b0;
        check("done_latency", k, skip ? 1 : N + 1);
        check("piso_enable_cycles", en_cnt, skip ? 0 : N + 1);
        check("product", Product, ref_product(a, b));
        @(negedge Clk);
        check("done_one_cycle", Done, 0);
        check("ready_after_done", Ready, 1);
        check("product_held", Product, ref_product(a, b));
        check("piso_data_held", Piso_Data, b);
    endtask

    initial begin
        int done_at[$];
        int cyc;
        logic [N-1:0] ra, rb;

        Reset        = 1'b1;
        Start        = 1'b0;
        Multiplicand = '0;
        Multiplier   = '0;
        repeat (2) @(negedge Clk);
        check("rst_ready", Ready, 1);
        check("rst_done", Done, 0);
        check("rst_product", Product, 0);
        check("rst_piso_enable", Piso_Enable, 0);
        check("rst_shift_load", Piso_Shift_Load, 0);
        check("rst_piso_data", Piso_Data, 0);
        Reset = 1'b0;
        @(negedge Clk);

        run_mult(8'd13, 8'd11, 1'b0);
        run_mult(8'd255, 8'd255, 1'b0);
        run_mult(8'd0, 8'd200, 1'b0);
        run_mult(8'd13, 8'd11, 1'b1);

        // Reset during the 4th RUN cycle
        Multiplicand = 8'd100;
        Multiplier   = 8'd77;
        Start        = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (4) @(negedge Clk);
        check("midrun_enable_before_reset", Piso_Enable, 1);
        Reset = 1'b1;
        @(negedge Clk);
        check("midrun_rst_ready", Ready, 1);
        check("midrun_rst_done", Done, 0);
        check("midrun_rst_product", Product, 0);
        check("midrun_rst_piso_enable", Piso_Enable, 0);
        check("midrun_rst_piso_data", Piso_Data, 0);
        // Reset beats a simultaneous Start
        Start        = 1'b1;
        Multiplicand = 8'd9;
        Multiplier   = 8'd9;
        @(negedge Clk);
        check("rst_beats_start_ready", Ready, 1);
        check("rst_beats_start_enable", Piso_Enable, 0);
        Reset = 1'b0;
        Start = 1'b0;
        @(negedge Clk);
        run_mult(8'd7, 8'd6, 1'b0);

        // Start held high: back-to-back relaunches
        Multiplicand = 8'd3;
        Multiplier   = 8'd5;
        Start        = 1'b1;
        cyc = 0;
        while (done_at.size() < 3 && cyc < 60) begin
            @(negedge Clk);
            cyc++;
            if (Done === 1'b1) begin
                done_at.push_back(cyc);
                check("held_product", Product, 15);
            end
        end
        Start = 1'b0;
        check("held_done_count", done_at.size(), 3);
        if (done_at.size() == 3) begin
            check("held_spacing_1", done_at[1] - done_at[0], N + 3);
            check("held_spacing_2", done_at[2] - done_at[1], N + 3);
        end
        repeat (2) @(negedge Clk);
        check("held_drain_ready", Ready, 1);

        // Randomized operands against the arithmetic model
        for (int i = 0; i < 10; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            if (i == 0) ra = '0;
            if (i == 1) rb = '0;
            run_mult(ra, rb, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
